instr_sequencer: RTL and testbench

Parametrised, buffered instruction decoder and sequencer for the systolic array. It accepts 64-bit host instructions through a valid/ready handshake and queues them in an internal FIFO. Each instruction is decoded into registered control pulses for the input, weight and output buffers and the accumulator. Unlike the single-cycle decoder, streaming opcodes become multi-cycle bursts of programmable length, and the block back-pressures the host while busy.

---
 rtl/instr_seq_pkg.sv | 28 ++
 rtl/instr_sequencer_fifo.sv | 56 +++++
 rtl/instr_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_seq_pkg.sv
// Shared opcodes, state_signal encodings and FSM states for the instruction sequencer.
package instr_seq_pkg;

    localparam logic [4:0] OP_NOP0      = 5'b00000;
    localparam logic [4:0] OP_MAC       = 5'b00001;
    localparam logic [4:0] OP_SEND_WT   = 5'b00010;
    localparam logic [4:0] OP_STORE_OUT = 5'b00011;
    localparam logic [4:0] OP_RX_INP    = 5'b00100;
    localparam logic [4:0] OP_RX_WT     = 5'b00101;
    localparam logic [4:0] OP_TX_OUT    = 5'b00110;
    localparam logic [4:0] OP_ACC_RST   = 5'b00111;
    localparam logic [4:0] OP_NOP1      = 5'b11111;

    localparam logic [1:0] SS_NOP    = 2'b00;
    localparam logic [1:0] SS_WE     = 2'b01;
    localparam logic [1:0] SS_STREAM = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ISSUE  = 2'b01,
        ST_STREAM = 2'b10
    } seq_state_e;

    function automatic logic op_is_illegal(input logic [4:0] op);
        return (op > OP_ACC_RST) && (op != OP_NOP1);
    endfunction

endpackage

// File: rtl/instr_sequencer_fifo.sv
// instr_fifo: synchronous FIFO with combinational head read; push ignored when full, pop ignored when empty.
module instr_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r <= count_r + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
        end
    end

    // Storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Buffered instruction sequencer: queues host instructions and issues registered buffer/accumulator strobes.
// Optional macro INSTR_SEQ_ILLEGAL_CHK_EN builds the sticky err_illegal check.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int INSTR_W    = 64,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 32,
    parameter int OBUF_AW    = 4,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [INSTR_W-1:0]  instr,
    output logic                inp_buf_we,
    output logic [ADDR_W-1:0]   inp_buf_addr,
    output logic [DATA_W-1:0]   inp_buf_data,
    output logic                wt_buf_we,
    output logic [ADDR_W-1:0]   wt_buf_addr,
    output logic [DATA_W-1:0]   wt_buf_data,
    output logic [OBUF_AW-1:0]  acc_to_op_buf_addr,
    output logic                acc_result_to_op_buf,
    output logic [OBUF_AW-1:0]  out_buf_addr,
    output logic                op_buffer_instr_for_sending_data,
    output logic                instr_for_accum_to_reset,
    output logic [1:0]          state_signal,
    output logic                i_mode,
    output logic                busy,
    output logic                err_illegal
);
    localparam int USED_W = 5 + ADDR_W + DATA_W + LEN_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    seq_state_e         state_r;
    seq_state_e         state_nxt_s;
    logic [LEN_W-1:0]   cnt_r;
    logic [LEN_W-1:0]   cnt_nxt_s;
    logic               push_s;
    logic               pop_s;
    logic               load_s;
    logic               hold_s;
    logic               full_s;
    logic               empty_s;
    logic [CNT_W-1:0]   count_s;
    logic [CNT_W-1:0]   count_nxt_s;
    logic [USED_W-1:0]  head_s;
    logic [4:0]         head_op_s;
    logic [ADDR_W-1:0]  head_addr_s;
    logic [DATA_W-1:0]  head_data_s;
    logic [LEN_W-1:0]   head_len_s;

    logic               inp_we_nxt_s;
    logic               wt_we_nxt_s;
    logic [ADDR_W-1:0]  inp_addr_nxt_s;
    logic [DATA_W-1:0]  inp_data_nxt_s;
    logic [ADDR_W-1:0]  wt_addr_nxt_s;
    logic [DATA_W-1:0]  wt_data_nxt_s;
    logic [OBUF_AW-1:0] acc_addr_nxt_s;
    logic               acc_st_nxt_s;
    logic [OBUF_AW-1:0] out_addr_nxt_s;
    logic               tx_nxt_s;
    logic               acc_rst_nxt_s;
    logic [1:0]         ss_nxt_s;
    logic               i_mode_nxt_s;

    // Only the decoded fields are queued; the ignored LSBs never enter the FIFO
    if (INSTR_W > USED_W) begin : g_pad
        logic unused_pad_s;
        assign unused_pad_s = ^instr[INSTR_W-USED_W-1:0];
    end

    assign push_s      = instr_valid & instr_ready & ~full_s;
    assign count_nxt_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);
    assign head_op_s   = head_s[USED_W-1 -: 5];
    assign head_addr_s = head_s[ADDR_W+DATA_W+LEN_W-1 -: ADDR_W];
    assign head_data_s = head_s[DATA_W+LEN_W-1 -: DATA_W];
    assign head_len_s  = head_s[LEN_W-1:0];

    instr_fifo #(
        .WIDTH (USED_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (instr[INSTR_W-1 -: USED_W]),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Next state: a stream holds while its counter is non-zero, otherwise the next entry is popped
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        pop_s       = 1'b0;
        load_s      = 1'b0;
        hold_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    load_s      = 1'b1;
                    cnt_nxt_s   = head_len_s;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE, ST_STREAM: begin
                if ((state_signal == SS_STREAM) && (cnt_r != {LEN_W{1'b0}})) begin
                    hold_s      = 1'b1;
                    cnt_nxt_s   = cnt_r - LEN_W'(1);
                    state_nxt_s = ST_STREAM;
                end else if (!empty_s) begin
                    pop_s       = 1'b1;
                    load_s      = 1'b1;
                    cnt_nxt_s   = head_len_s;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Decode of the entry being popped, or hold of the running stream
    always_comb begin
        inp_we_nxt_s   = 1'b0;
        wt_we_nxt_s    = 1'b0;
        inp_addr_nxt_s = {ADDR_W{1'b0}};
        inp_data_nxt_s = {DATA_W{1'b0}};
        wt_addr_nxt_s  = {ADDR_W{1'b0}};
        wt_data_nxt_s  = {DATA_W{1'b0}};
        acc_addr_nxt_s = {OBUF_AW{1'b0}};
        acc_st_nxt_s   = 1'b0;
        out_addr_nxt_s = {OBUF_AW{1'b0}};
        tx_nxt_s       = 1'b0;
        acc_rst_nxt_s  = 1'b0;
        ss_nxt_s       = SS_NOP;
        i_mode_nxt_s   = 1'b0;
        if (hold_s) begin
            ss_nxt_s     = state_signal;
            i_mode_nxt_s = i_mode;
        end else if (load_s) begin
            case (head_op_s)
                OP_MAC: begin
                    ss_nxt_s = SS_STREAM;
                end
                OP_SEND_WT: begin
                    ss_nxt_s     = SS_STREAM;
                    i_mode_nxt_s = 1'b1;
                end
                OP_STORE_OUT: begin
                    ss_nxt_s       = SS_WE;
                    acc_addr_nxt_s = head_addr_s[OBUF_AW-1:0];
                    acc_st_nxt_s   = 1'b1;
                end
                OP_RX_INP: begin
                    ss_nxt_s       = SS_WE;
                    inp_we_nxt_s   = 1'b1;
                    inp_addr_nxt_s = head_addr_s;
                    inp_data_nxt_s = head_data_s;
                end
                OP_RX_WT: begin
                    ss_nxt_s      = SS_WE;
                    wt_we_nxt_s   = 1'b1;
                    wt_addr_nxt_s = head_addr_s;
                    wt_data_nxt_s = head_data_s;
                end
                OP_TX_OUT: begin
                    ss_nxt_s       = SS_WE;
                    out_addr_nxt_s = head_addr_s[OBUF_AW-1:0];
                    tx_nxt_s       = 1'b1;
                end
                OP_ACC_RST: begin
                    ss_nxt_s      = SS_WE;
                    acc_rst_nxt_s = 1'b1;
                end
                default: begin
                    ss_nxt_s = SS_NOP;
                end
            endcase
        end else begin
            ss_nxt_s = SS_NOP;
        end
    end

    // State and registered outputs; busy/ready reflect post-edge FSM and FIFO occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r                          <= ST_IDLE;
            cnt_r                            <= {LEN_W{1'b0}};
            instr_ready                      <= 1'b0;
            busy                             <= 1'b0;
            inp_buf_we                       <= 1'b0;
            inp_buf_addr                     <= {ADDR_W{1'b0}};
            inp_buf_data                     <= {DATA_W{1'b0}};
            wt_buf_we                        <= 1'b0;
            wt_buf_addr                      <= {ADDR_W{1'b0}};
            wt_buf_data                      <= {DATA_W{1'b0}};
            acc_to_op_buf_addr               <= {OBUF_AW{1'b0}};
            acc_result_to_op_buf             <= 1'b0;
            out_buf_addr                     <= {OBUF_AW{1'b0}};
            op_buffer_instr_for_sending_data <= 1'b0;
            instr_for_accum_to_reset         <= 1'b0;
            state_signal                     <= SS_NOP;
            i_mode                           <= 1'b0;
        end else begin
            state_r                          <= state_nxt_s;
            cnt_r                            <= cnt_nxt_s;
            instr_ready                      <= (count_nxt_s != CNT_W'(FIFO_DEPTH));
            busy                             <= (state_nxt_s != ST_IDLE) || (count_nxt_s != {CNT_W{1'b0}});
            inp_buf_we                       <= inp_we_nxt_s;
            inp_buf_addr                     <= inp_addr_nxt_s;
            inp_buf_data                     <= inp_data_nxt_s;
            wt_buf_we                        <= wt_we_nxt_s;
            wt_buf_addr                      <= wt_addr_nxt_s;
            wt_buf_data                      <= wt_data_nxt_s;
            acc_to_op_buf_addr               <= acc_addr_nxt_s;
            acc_result_to_op_buf             <= acc_st_nxt_s;
            out_buf_addr                     <= out_addr_nxt_s;
            op_buffer_instr_for_sending_data <= tx_nxt_s;
            instr_for_accum_to_reset         <= acc_rst_nxt_s;
            state_signal                     <= ss_nxt_s;
            i_mode                           <= i_mode_nxt_s;
        end
    end

`ifdef INSTR_SEQ_ILLEGAL_CHK_EN
    // Sticky until reset; raised in the same cycle the offending entry issues
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_illegal <= 1'b0;
        end else if (load_s && op_is_illegal(head_op_s)) begin
            err_illegal <= 1'b1;
        end else begin
            err_illegal <= err_illegal;
        end
    end
`else
    assign err_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed steps plus random traffic against a queue-based model.
module tb_instr_sequencer;
    localparam int INSTR_W    = 64;
    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 32;
    localparam int OBUF_AW    = 4;
    localparam int LEN_W      = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int OUT_W      = 113;
`ifdef INSTR_SEQ_ILLEGAL_CHK_EN
    localparam logic EXP_ERR_EN = 1'b1;
`else
    localparam logic EXP_ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic instr_valid;
    logic instr_ready;
    logic [INSTR_W-1:0] instr;
    logic inp_buf_we, wt_buf_we;
    logic [ADDR_W-1:0] inp_buf_addr, wt_buf_addr;
    logic [DATA_W-1:0] inp_buf_data, wt_buf_data;
    logic [OBUF_AW-1:0] acc_to_op_buf_addr, out_buf_addr;
    logic acc_result_to_op_buf, op_buffer_instr_for_sending_data, instr_for_accum_to_reset;
    logic [1:0] state_signal;
    logic i_mode, busy, err_illegal;

    instr_sequencer #(
        .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .OBUF_AW(OBUF_AW), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .inp_buf_we(inp_buf_we), .inp_buf_addr(inp_buf_addr), .inp_buf_data(inp_buf_data),
        .wt_buf_we(wt_buf_we), .wt_buf_addr(wt_buf_addr), .wt_buf_data(wt_buf_data),
        .acc_to_op_buf_addr(acc_to_op_buf_addr), .acc_result_to_op_buf(acc_result_to_op_buf),
        .out_buf_addr(out_buf_addr), .op_buffer_instr_for_sending_data(op_buffer_instr_for_sending_data),
        .instr_for_accum_to_reset(instr_for_accum_to_reset), .state_signal(state_signal),
        .i_mode(i_mode), .busy(busy), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: a queue of pending instructions plus the one currently shown
    logic [INSTR_W-1:0] q[$];
    logic [INSTR_W-1:0] m_cur;
    bit m_active = 1'b0;
    int m_remain = 0;
    bit m_err    = 1'b0;
    bit m_rst_hi = 1'b0;
    bit accepted = 1'b0;

    int ss_cnt = 0, im_cnt = 0;
    bit saw_full = 1'b0;
    int store_cyc = -100, tx_cyc = -100, rst_cyc = -100;
    logic [DATA_W-1:0] rx_log[$];

    function automatic logic [INSTR_W-1:0] mk(input logic [4:0] op, input logic [ADDR_W-1:0] a,
                                              input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l);
        return {op, a, d, l, 4'b0000};
    endfunction

    function automatic bit is_illegal(input logic [4:0] op);
        return (op >= 5'd8) && (op != 5'd31);
    endfunction

    function automatic logic [OUT_W-1:0] dut_vec();
        return {instr_ready, busy, err_illegal, state_signal, i_mode, inp_buf_we, inp_buf_addr, inp_buf_data,
                wt_buf_we, wt_buf_addr, wt_buf_data, acc_to_op_buf_addr, acc_result_to_op_buf,
                out_buf_addr, op_buffer_instr_for_sending_data, instr_for_accum_to_reset};
    endfunction

    function automatic logic [OUT_W-1:0] model_vec();
        logic rdy, bsy, im, iwe, wwe, ast, tx, ar;
        logic [1:0] ss;
        logic [ADDR_W-1:0] ia, wa, a;
        logic [DATA_W-1:0] id, wd;
        logic [OBUF_AW-1:0] aa, oa;
        logic [4:0] op;
        {im, iwe, wwe, ast, tx, ar} = 6'b0;
        ss = 2'b00; ia = '0; wa = '0; id = '0; wd = '0; aa = '0; oa = '0;
        rdy = m_rst_hi && (q.size() < FIFO_DEPTH);
        bsy = m_active || (q.size() != 0);
        op  = m_cur[63:59];
        a   = m_cur[58:44];
        if (m_active) begin
            case (op)
                5'd1: ss = 2'b10;
                5'd2: begin ss = 2'b10; im = 1'b1; end
                5'd3: begin ss = 2'b01; aa = a[OBUF_AW-1:0]; ast = 1'b1; end
                5'd4: begin ss = 2'b01; iwe = 1'b1; ia = a; id = m_cur[43:12]; end
                5'd5: begin ss = 2'b01; wwe = 1'b1; wa = a; wd = m_cur[43:12]; end
                5'd6: begin ss = 2'b01; oa = a[OBUF_AW-1:0]; tx = 1'b1; end
                5'd7: begin ss = 2'b01; ar = 1'b1; end
                default: ss = 2'b00;
            endcase
        end
        return {rdy, bsy, m_err, ss, im, iwe, ia, id, wwe, wa, wd, aa, ast, oa, tx, ar};
    endfunction

    // Advance the model over one rising edge, using the inputs the DUT sampled
    task automatic model_edge();
        bit do_push;
        if (!rst_n) begin
            q.delete();
            m_active = 1'b0; m_err = 1'b0; m_rst_hi = 1'b0; accepted = 1'b0;
            return;
        end
        do_push = instr_valid && m_rst_hi && (q.size() < FIFO_DEPTH);
        if (m_active && m_remain > 0) begin
            m_remain--;
        end else if (q.size() > 0) begin
            m_cur    = q.pop_front();
            m_active = 1'b1;
            m_remain = (m_cur[63:59] == 5'd1 || m_cur[63:59] == 5'd2) ? int'(m_cur[11:4]) : 0;
            if (EXP_ERR_EN && is_illegal(m_cur[63:59])) m_err = 1'b1;
        end else begin
            m_active = 1'b0;
        end
        if (do_push) q.push_back(instr);
        m_rst_hi = 1'b1;
        accepted = do_push;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic observe();
        check($sformatf("outputs@cycle%0d", cyc), 128'(dut_vec()), 128'(model_vec()));
        if (state_signal == 2'b10) ss_cnt++;
        if (i_mode) im_cnt++;
        if (inp_buf_we) rx_log.push_back(inp_buf_data);
        if (rst_n && instr_ready === 1'b0) saw_full = 1'b1;
        if (acc_result_to_op_buf) store_cyc = cyc;
        if (op_buffer_instr_for_sending_data) tx_cyc = cyc;
        if (instr_for_accum_to_reset) rst_cyc = cyc;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        observe();
    endtask

    task automatic push(input logic [INSTR_W-1:0] x);
        instr_valid = 1'b1;
        instr = x;
        accepted = 1'b0;
        for (int i = 0; i < 400 && !accepted; i++) tick();
        if (!accepted) check("push_timeout", 128'(instr_ready), 128'(1));
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((m_active || q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (m_active || q.size() != 0) check("wait_idle_timeout", 128'(busy), 128'(0));
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
        repeat (3) tick();
        check("reset_ready_low", 128'(instr_ready), 128'(0));
        rst_n = 1'b1;
        tick();
        check("ready_after_release", 128'(instr_ready), 128'(1));

        // Single RX_INP: strobe visible two cycles after the push edge
        instr_valid = 1'b1; instr = mk(5'd4, 15'h1234, 32'hDEADBEEF, 8'd0);
        tick();
        instr_valid = 1'b0;
        check("rx_inp_we_T+1", 128'(inp_buf_we), 128'(0));
        tick();
        check("rx_inp_we_T+2", 128'(inp_buf_we), 128'(1));
        check("rx_inp_addr", 128'(inp_buf_addr), 128'(15'h1234));
        check("rx_inp_data", 128'(inp_buf_data), 128'(32'hDEADBEEF));
        check("rx_inp_ss", 128'(state_signal), 128'(2'b01));
        tick();
        check("rx_inp_we_T+3", 128'(inp_buf_we), 128'(0));
        wait_idle(20);

        // Stream lengths
        ss_cnt = 0; im_cnt = 0;
        push(mk(5'd1, 15'd0, 32'd0, 8'd3));
        wait_idle(50);
        check("mac_len3_cycles", 128'(ss_cnt), 128'(4));
        check("mac_len3_imode", 128'(im_cnt), 128'(0));
        ss_cnt = 0; im_cnt = 0;
        push(mk(5'd2, 15'd0, 32'd0, 8'd0));
        wait_idle(50);
        check("sendwt_len0_cycles", 128'(ss_cnt), 128'(1));
        check("sendwt_len0_imode", 128'(im_cnt), 128'(1));
        ss_cnt = 0;
        push(mk(5'd1, 15'd0, 32'd0, 8'd255));
        wait_idle(400);
        check("mac_maxlen_cycles", 128'(ss_cnt), 128'(256));

        // Six pushes behind a long stream: back-pressure, order preserved
        saw_full = 1'b0; rx_log.delete();
        push(mk(5'd1, 15'd0, 32'd0, 8'd20));
        for (int k = 0; k < 6; k++) push(mk(5'd4, 15'(k), 32'hA000_0000 + 32'(k), 8'd0));
        wait_idle(200);
        check("backpressure_seen", 128'(saw_full), 128'(1));
        check("six_rx_count", 128'(rx_log.size()), 128'(6));
        for (int k = 0; k < 6 && k < rx_log.size(); k++)
            check($sformatf("six_rx_order%0d", k), 128'(rx_log[k]), 128'(32'hA000_0000 + 32'(k)));

        // Adjacent single-cycle pulses
        push(mk(5'd3, 15'd5, 32'd0, 8'd0));
        push(mk(5'd6, 15'd9, 32'd0, 8'd0));
        push(mk(5'd7, 15'd0, 32'd0, 8'd0));
        wait_idle(30);
        check("tx_after_store", 128'(tx_cyc - store_cyc), 128'(1));
        check("accrst_after_tx", 128'(rst_cyc - tx_cyc), 128'(1));

        // Reset in stream cycle 2 discards the queue
        ss_cnt = 0;
        push(mk(5'd1, 15'd0, 32'd0, 8'd10));
        push(mk(5'd4, 15'd1, 32'h1111_1111, 8'd0));
        push(mk(5'd4, 15'd2, 32'h2222_2222, 8'd0));
        for (int i = 0; i < 20 && ss_cnt < 2; i++) tick();
        rst_n = 1'b0;
        tick();
        check("midstream_rst_outputs", 128'(dut_vec()), 128'(0));
        rst_n = 1'b1;
        rx_log.delete();
        repeat (5) tick();
        check("midstream_rst_busy", 128'(busy), 128'(0));
        check("midstream_rst_discard", 128'(rx_log.size()), 128'(0));

        // Undefined opcode and stickiness
        push(mk(5'b01010, 15'd3, 32'd7, 8'd0));
        wait_idle(20);
        check("illegal_flag", 128'(err_illegal), 128'(EXP_ERR_EN));
        push(mk(5'd5, 15'd4, 32'h55, 8'd0));
        wait_idle(20);
        check("illegal_sticky", 128'(err_illegal), 128'(EXP_ERR_EN));

        // Random traffic, including ignored LSBs and undefined opcodes
        for (int i = 0; i < 300; i++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            instr_valid = 1'($urandom_range(0, 1));
            instr = mk(op, 15'($urandom), $urandom, 8'($urandom_range(0, 3)));
            instr[3:0] = 4'($urandom);
            tick();
        end
        instr_valid = 1'b0;
        wait_idle(2000);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
